// File: rtl/key_conditioner.sv
// key_conditioner: N-channel push-button conditioner.
// Each channel passes through a two-flop synchroniser and a polarity fix. A
// debounce FSM then produces a clean level and one-cycle press/release
// strobes, plus a long-press strobe after a sustained hold.
// Optional feature macro: KEY_AUTOREPEAT_EN. When it is defined, `press`
// re-fires every REPEAT_CYCLES while the button stays held after long_press.
// dbg_state exposes every channel FSM as a 2-bit field:
// channel i occupies bits [2i+1:2i], with IDLE=0, DB_PRESS=1, HELD=2, DB_REL=3.
module key_conditioner #(
    parameter int             N             = 3,
    parameter logic [N-1:0]   ACTIVE_MASK   = {N{1'b1}},
    parameter int             DB_CYCLES     = 500000,
    parameter int             LONG_CYCLES   = 25000000,
    parameter int             REPEAT_CYCLES = 5000000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N-1:0]     btn_in,
    output logic [N-1:0]     level,
    output logic [N-1:0]     press,
    output logic [N-1:0]     rel,
    output logic [N-1:0]     long_press,
    output logic [2*N-1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_e;

    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int DB_W     = $clog2(DB_CYCLES + 1);
    localparam int HW       = $clog2(HOLD_MAX + 1);

    // The debounce decision is taken on the sample that would bring the count
    // to DB_CYCLES-1. Together with the entry sample, this accepts exactly
    // DB_CYCLES agreeing samples.
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 2);
    localparam logic [HW-1:0]   LONG_LAST = HW'(LONG_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [HW-1:0]   RPT_LAST  = HW'(REPEAT_CYCLES - 1);
`else
    localparam logic [HW-1:0]   HOLD_SAT  = HW'(LONG_CYCLES);
`endif

    for (genvar i = 0; i < N; i++) begin : g_ch
        // Pin level while the button is released; the synchroniser resets to it.
        localparam logic PIN_IDLE = ~ACTIVE_MASK[i];

        logic            sync1_q, sync2_q;
        logic            s;
        state_e          state_q, state_d;
        logic [DB_W-1:0] db_q, db_d;
        logic [HW-1:0]   hold_q, hold_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            rel_q, rel_d;
        logic            long_q, long_d;
`ifdef KEY_AUTOREPEAT_EN
        // Set once long_press has fired; the hold counter then times repeats.
        logic            rpt_q, rpt_d;
`endif

        // Two-flop synchroniser for the asynchronous pin.
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                sync1_q <= PIN_IDLE;
                sync2_q <= PIN_IDLE;
            end else begin
                sync1_q <= btn_in[i];
                sync2_q <= sync1_q;
            end
        end

        // 1 = pressed, regardless of pin polarity.
        assign s = sync2_q ^ PIN_IDLE;

        // FSM state, counters and registered outputs.
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                state_q <= IDLE;
                db_q    <= '0;
                hold_q  <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                rpt_q   <= 1'b0;
`endif
            end else begin
                state_q <= state_d;
                db_q    <= db_d;
                hold_q  <= hold_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
`ifdef KEY_AUTOREPEAT_EN
                rpt_q   <= rpt_d;
`endif
            end
        end

        // Next-state logic: debounce in both directions, then hold timing.
        always_comb begin
            state_d = state_q;
            db_d    = db_q;
            hold_d  = hold_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_d   = rpt_q;
`endif
            case (state_q)
                IDLE: begin
                    level_d = 1'b0;
                    if (s) begin
                        db_d    = '0;
                        state_d = DB_PRESS;
                    end
                end
                DB_PRESS: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (db_q == DB_LAST) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        hold_d  = '0;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_d   = 1'b0;
`endif
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        db_d    = '0;
                        state_d = DB_REL;
                    end else begin
`ifdef KEY_AUTOREPEAT_EN
                        if (!rpt_q) begin
                            if (hold_q == LONG_LAST) begin
                                long_d = 1'b1;
                                hold_d = '0;
                                rpt_d  = 1'b1;
                            end else begin
                                hold_d = hold_q + HW'(1);
                            end
                        end else begin
                            if (hold_q == RPT_LAST) begin
                                press_d = 1'b1;
                                hold_d  = '0;
                            end else begin
                                hold_d = hold_q + HW'(1);
                            end
                        end
`else
                        if (hold_q == LONG_LAST) begin
                            long_d = 1'b1;
                        end
                        if (hold_q != HOLD_SAT) begin
                            hold_d = hold_q + HW'(1);
                        end
`endif
                    end
                end
                DB_REL: begin
                    // Hold timing is frozen here; a bounce back resumes it.
                    if (s) begin
                        state_d = HELD;
                    end else if (db_q == DB_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        assign level[i]           = level_q;
        assign press[i]           = press_q;
        assign rel[i]             = rel_q;
        assign long_press[i]      = long_q;
        assign dbg_state[2*i +: 2] = state_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with N=3, ACTIVE_MASK=3'b011, DB_CYCLES=4,
// LONG_CYCLES=20, REPEAT_CYCLES=8.
// Stimulus is applied on the falling edge. A pin change driven at the falling
// edge of cycle c is first sampled at rising edge c+1. The resulting strobe is
// visible at the falling edge of cycle c+6.
module tb_key_conditioner;

  localparam int N = 3;
  localparam logic [N-1:0] AM = 3'b011;
  localparam logic [N-1:0] PIN_IDLE = 3'b100;
  localparam int LAT = 6;        // DB_CYCLES + 2
  localparam int LONG = 20;
  localparam int RPT = 8;
  localparam int K_PRESS = 0;
  localparam int K_REL = 1;
  localparam int K_LONG = 2;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk;
  logic clr;
  logic [N-1:0] btn_in;
  logic [N-1:0] level, press, rel, long_press;
  logic [2*N-1:0] dbg_state;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;

  // Each entry holds {cycle[15:0], kind[1:0], channel[1:0]}.
  logic [19:0] exp_q[$];

  key_conditioner #(
    .N(N), .ACTIVE_MASK(AM), .DB_CYCLES(4), .LONG_CYCLES(LONG), .REPEAT_CYCLES(RPT)
  ) dut (
    .clk(clk), .clr(clr), .btn_in(btn_in),
    .level(level), .press(press), .rel(rel), .long_press(long_press),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] make_ev(int c, int kind, int ch);
    return {c[15:0], kind[1:0], ch[1:0]};
  endfunction

  task automatic push_ev(int c, int kind, logic [N-1:0] mask);
    for (int ch = 0; ch < N; ch++)
      if (mask[ch]) exp_q.push_back(make_ev(c, kind, ch));
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_neg(int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard: every observed strobe must match a queued expectation
  always @(negedge clk) begin : mon
    logic bit_v;
    int found;
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < N; ch++) begin
        bit_v = (k == K_PRESS) ? press[ch] : (k == K_REL) ? rel[ch] : long_press[ch];
        if (bit_v === 1'b1) begin
          strobe_cnt++;
          total++;
          found = -1;
          for (int i = 0; i < exp_q.size(); i++)
            if (found < 0 && exp_q[i] == make_ev(cyc, k, ch)) found = i;
          if (found >= 0) exp_q.delete(found);
          else begin
            bad++;
            $display("FAIL strobe: unexpected kind=%0d ch=%0d at cyc %0d", k, ch, cyc);
          end
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][19:4] <= cyc[15:0]) begin
        total++;
        bad++;
        $display("FAIL missed: kind=%0d ch=%0d due cyc %0d, now %0d",
                 exp_q[i][3:2], exp_q[i][1:0], exp_q[i][19:4], cyc);
        exp_q.delete(i);
      end
    end
  end

  typedef struct {
    logic [N-1:0] mask;
    int           hold;
    logic [N-1:0] exp_level;
    bit           exp_long;
    int           exp_rpt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c, r, q, cf, nrpt;
    vecs[0] = '{mask: 3'b001, hold: 10, exp_level: 3'b001, exp_long: 1'b0, exp_rpt: 0};
    vecs[1] = '{mask: 3'b011, hold: 10, exp_level: 3'b011, exp_long: 1'b0, exp_rpt: 0};
    vecs[2] = '{mask: 3'b100, hold: 45, exp_level: 3'b100, exp_long: 1'b1, exp_rpt: 2};
    vecs[3] = '{mask: 3'b111, hold: 30, exp_level: 3'b111, exp_long: 1'b1, exp_rpt: 0};
    vecs[4] = '{mask: 3'b010, hold: 6,  exp_level: 3'b010, exp_long: 1'b0, exp_rpt: 0};

    // reset with all pins inactive
    clr = 1'b0;
    btn_in = PIN_IDLE;
    wait_neg(3);
    check("rst_level", level, 0);
    check("rst_press", press, 0);
    check("rst_rel", rel, 0);
    check("rst_long", long_press, 0);
    check("rst_state", dbg_state, 0);
    clr = 1'b1;
    wait_neg(50);
    check("idle_strobes", strobe_cnt, 0);
    check("idle_level", level, 0);

    // table-driven press/hold/release vectors
    for (int v = 0; v < 5; v++) begin
      c = cyc;
      btn_in = PIN_IDLE ^ vecs[v].mask;
      push_ev(c + LAT, K_PRESS, vecs[v].mask);
      if (vecs[v].exp_long) push_ev(c + LAT + LONG, K_LONG, vecs[v].mask);
      nrpt = AR ? vecs[v].exp_rpt : 0;
      for (int j = 1; j <= nrpt; j++) push_ev(c + LAT + LONG + j * RPT, K_PRESS, vecs[v].mask);
      wait_neg(LAT - 1);
      check($sformatf("v%0d_lat_lo", v), level, 0);
      wait_neg(1);
      check($sformatf("v%0d_lat_hi", v), level, vecs[v].exp_level);
      wait_neg(vecs[v].hold - LAT);
      check($sformatf("v%0d_hold", v), level, vecs[v].exp_level);
      r = cyc;
      btn_in = PIN_IDLE;
      push_ev(r + LAT, K_REL, vecs[v].mask);
      wait_neg(LAT - 1);
      check($sformatf("v%0d_rel_lo", v), level, vecs[v].exp_level);
      wait_neg(1);
      check($sformatf("v%0d_rel_hi", v), level, 0);
      wait_neg(8);
    end

    // ch1 press bounce 1-0-1-0-1, then a 2-cycle release glitch, then release
    btn_in = PIN_IDLE ^ 3'b010; wait_neg(2);
    btn_in = PIN_IDLE;          wait_neg(2);
    btn_in = PIN_IDLE ^ 3'b010; wait_neg(2);
    btn_in = PIN_IDLE;          wait_neg(2);
    cf = cyc;
    btn_in = PIN_IDLE ^ 3'b010;
    push_ev(cf + LAT, K_PRESS, 3'b010);
    wait_neg(LAT - 1);
    check("bounce_lat_lo", level, 0);
    wait_neg(1);
    check("bounce_lat_hi", level, 3'b010);
    wait_neg(2);
    btn_in = PIN_IDLE;          wait_neg(2);
    btn_in = PIN_IDLE ^ 3'b010; wait_neg(8);
    check("glitch_level", level, 3'b010);
    r = cyc;
    btn_in = PIN_IDLE;
    push_ev(r + LAT, K_REL, 3'b010);
    wait_neg(LAT);
    check("bounce_rel", level, 0);
    wait_neg(8);

    // reset while ch0 is held
    c = cyc;
    btn_in = PIN_IDLE ^ 3'b001;
    push_ev(c + LAT, K_PRESS, 3'b001);
    wait_neg(10);
    check("mid_level_before", level, 3'b001);
    clr = 1'b0;
    #1;
    check("mid_level_async", level, 0);
    wait_neg(3);
    q = cyc;
    clr = 1'b1;
    push_ev(q + LAT, K_PRESS, 3'b001);
    wait_neg(LAT - 1);
    check("mid_fresh_lo", level, 0);
    wait_neg(1);
    check("mid_fresh_hi", level, 3'b001);
    wait_neg(4);
    r = cyc;
    btn_in = PIN_IDLE;
    push_ev(r + LAT, K_REL, 3'b001);
    wait_neg(LAT + 20);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
